// File: rtl/sumador_botones_if.sv
// sumador_botones_if: button, start value and count/flag outputs of the up-counter
interface sumador_botones_if #(parameter int N = 4);
  logic         btn_add;
  logic [N-1:0] data_in;
  logic [N-1:0] data_out;
  logic         carry;
  logic         pressed;
  modport master (output btn_add, data_in, input data_out, carry, pressed);
  modport slave  (input btn_add, data_in, output data_out, carry, pressed);
endinterface

// File: rtl/sumador_botones.sv
// sumador_botones: debounced active-low push button stepping an N-bit up-counter
// that loads a start value after reset and wraps or saturates at the top.
module sumador_botones #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SATURATE        = 0
) (
  input logic          clk,
  input logic          btn_rst,
  sumador_botones_if.slave bus
);
  localparam int           CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N-1:0]  TOP  = '1;
  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_HELD} state_t;
  state_t        state_q, state_d;
  logic          s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  data_q, data_d;
  logic          acc;
  always_comb begin
    s1_d    = bus.btn_add;
    s2_d    = s1_q;
    acc     = (s2_q != deb_q) && (cnt_q == CMAX);
    deb_d   = acc ? s2_q : deb_q;
    cnt_d   = (s2_q == deb_q || acc) ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    data_d  = data_q;
    carry_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        data_d  = bus.data_in;
        state_d = S_IDLE;
      end
      S_IDLE: if (acc && deb_q) begin
        // top of range: wrap to zero or hold, flagging the boundary either way
        data_d  = (data_q != TOP) ? data_q + 1'b1 : (SATURATE != 0) ? data_q : '0;
        carry_d = (data_q == TOP);
        state_d = S_HELD;
      end
      S_HELD: state_d = (acc && !deb_q) ? S_IDLE : S_HELD;
      default: state_d = S_LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge btn_rst) begin
    if (!btn_rst) begin
      state_q <= S_LOAD;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end
  assign bus.data_out = data_q;
  assign bus.carry    = carry_q;
  assign bus.pressed  = ~deb_q;
endmodule

// File: tb/tb_sumador_botones.sv
// tb_sumador_botones: wrap (dut0) and saturate (dut1) counters; queued expected
// count/carry events are popped by monitors, plus directed latency checks.
module tb_sumador_botones;
  typedef struct packed {logic [3:0] d; logic c;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   vectors = 0;
  int   errors = 0;
  logic any_p;
  exp_t q0[$], q1[$];
  logic [3:0] p0, p1;
  sumador_botones_if #(.N(4)) b0 ();
  sumador_botones_if #(.N(4)) b1 ();
  sumador_botones #(.N(4), .DEBOUNCE_CYCLES(4), .SATURATE(0)) dut0 (.clk(clk), .btn_rst(rst_n), .bus(b0));
  sumador_botones #(.N(4), .DEBOUNCE_CYCLES(4), .SATURATE(1)) dut1 (.clk(clk), .btn_rst(rst_n), .bus(b1));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (b0.data_out != p0 || b0.carry)) begin
      if (q0.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL dut0 unexpected event: data %0d carry %0d", b0.data_out, b0.carry);
      end else begin
        e = q0.pop_front();
        chk("dut0 sb data", int'(b0.data_out), int'(e.d));
        chk("dut0 sb carry", int'(b0.carry), int'(e.c));
      end
    end
    p0 = b0.data_out;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (b1.data_out != p1 || b1.carry)) begin
      if (q1.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL dut1 unexpected event: data %0d carry %0d", b1.data_out, b1.carry);
      end else begin
        e = q1.pop_front();
        chk("dut1 sb data", int'(b1.data_out), int'(e.d));
        chk("dut1 sb carry", int'(b1.carry), int'(e.c));
      end
    end
    p1 = b1.data_out;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int dout(input int s);
    return s != 0 ? int'(b1.data_out) : int'(b0.data_out);
  endfunction
  function automatic int cout(input int s);
    return s != 0 ? int'(b1.carry) : int'(b0.carry);
  endfunction
  function automatic int pout(input int s);
    return s != 0 ? int'(b1.pressed) : int'(b0.pressed);
  endfunction

  task automatic setbtn(input int s, input logic v);
    if (s != 0) b1.btn_add = v;
    else b0.btn_add = v;
  endtask

  task automatic doreset(input logic [3:0] d0);
    rst_n = 1'b0;
    #1;
    chk("rst data0", int'(b0.data_out), 0);
    chk("rst carry0", int'(b0.carry), 0);
    chk("rst pressed0", int'(b0.pressed), 0);
    chk("rst data1", int'(b1.data_out), 0);
    b0.data_in = d0;
    tick(2);
    q0.push_back('{d0, 1'b0});
    q1.push_back('{4'd15, 1'b0});
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);
    chk("load data0", int'(b0.data_out), int'(d0));
    chk("load data1", int'(b1.data_out), 15);
  endtask

  task automatic press(input int s, input int exp_d, input int exp_c);
    setbtn(s, 1'b0);
    tick(5);
    chk("pre-accept pressed", pout(s), 0);
    tick(1);
    chk("edge6 data", dout(s), exp_d);
    chk("edge6 carry", cout(s), exp_c);
    chk("edge6 pressed", pout(s), 1);
    tick(1);
    chk("carry one cycle", cout(s), 0);
    tick(2);
    chk("held data", dout(s), exp_d);
    setbtn(s, 1'b1);
    tick(5);
    chk("release edge5 pressed", pout(s), 1);
    tick(1);
    chk("release edge6 pressed", pout(s), 0);
    tick(2);
  endtask

  task automatic hold(input logic v, input int n);
    b0.btn_add = v;
    repeat (n) begin
      tick(1);
      any_p = any_p | b0.pressed;
    end
  endtask

  initial begin
    b0.btn_add = 1'b1;
    b1.btn_add = 1'b1;
    b0.data_in = 4'd0;
    b1.data_in = 4'd15;
    #2;
    doreset(4'd11);
    q0.push_back('{4'd12, 1'b0});
    press(0, 12, 0);
    any_p = 1'b0;
    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 3);
    hold(1'b1, 8);
    chk("bounce pressed never", int'(any_p), 0);
    chk("bounce data", int'(b0.data_out), 12);
    doreset(4'd14);
    q0.push_back('{4'd15, 1'b0});
    press(0, 15, 0);
    q0.push_back('{4'd0, 1'b1});
    press(0, 0, 1);
    q1.push_back('{4'd15, 1'b1});
    press(1, 15, 1);
    doreset(4'd5);
    b0.btn_add = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("midreset data", int'(b0.data_out), 0);
    chk("midreset pressed", int'(b0.pressed), 0);
    q0.push_back('{4'd5, 1'b0});
    q0.push_back('{4'd6, 1'b0});
    q1.push_back('{4'd15, 1'b0});
    tick(2);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);
    chk("reload data", int'(b0.data_out), 5);
    tick(4);
    chk("held-through edge5", int'(b0.data_out), 5);
    tick(1);
    chk("held-through edge6", int'(b0.data_out), 6);
    b0.btn_add = 1'b1;
    tick(10);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
